// File: rtl/csrng_cmd_sched.sv
`default_nettype none
// ============================================================================
// csrng_cmd_sched: round-robin scheduler for CSRNG app commands. It sequences
// CTR_DRBG request pulses and reports status, with a watchdog on each wait.
// Revision: 1.0
// ============================================================================
module csrng_cmd_sched #(
  parameter int  NumApps  = 3,
  parameter int  TimeoutW = 16,
  localparam int IdxW     = (NumApps > 1) ? $clog2(NumApps) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [NumApps-1:0]    app_en_i,
  input  logic [NumApps-1:0]    acmd_avail_i,
  output logic [NumApps-1:0]    acmd_accept_o,
  input  logic [3*NumApps-1:0]  acmd_i,
  input  logic [NumApps-1:0]    acmd_eop_i,
  input  logic [NumApps-1:0]    flag0_i,
  input  logic                  ctr_drbg_cmd_req_rdy_i,
  output logic                  cmd_entropy_req_o,
  input  logic                  cmd_entropy_avail_i,
  output logic                  instant_req_o,
  output logic                  reseed_req_o,
  output logic                  generate_req_o,
  output logic                  update_req_o,
  output logic                  uninstant_req_o,
  output logic                  clr_adata_packer_o,
  input  logic                  cmd_complete_i,
  input  logic [TimeoutW-1:0]   timeout_limit_i,
  input  logic                  local_escalate_i,
  output logic [IdxW-1:0]       grant_idx_o,
  output logic                  cmd_sts_valid_o,
  output logic                  cmd_sts_err_o,
  output logic [3:0]            main_sm_state_o,
  output logic                  main_sm_err_o,
  output logic                  timeout_err_o
);

  localparam logic [2:0] cmd_ins = 3'd1;
  localparam logic [2:0] cmd_res = 3'd2;
  localparam logic [2:0] cmd_gen = 3'd3;
  localparam logic [2:0] cmd_upd = 3'd4;
  localparam logic [2:0] cmd_uni = 3'd5;

  typedef enum logic [3:0] {
    st_idle      = 4'd0,
    st_parse     = 4'd1,
    st_prep      = 4'd2,
    st_req       = 4'd3,
    st_clr_adata = 4'd4,
    st_comp_wait = 4'd5,
    st_error     = 4'd6
  } state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       grant_q, grant_d;
  logic [IdxW-1:0]       rr_q, rr_d;
  logic [2:0]            kind_q, kind_d;
  logic [TimeoutW-1:0]   wdog_q, wdog_d;
  logic                  timeout_err_q;
  logic                  timeout_set;

  logic [NumApps-1:0]    eligible;
  logic [NumApps-1:0]    pick_onehot;
  logic [IdxW-1:0]       pick_idx, hi_idx, lo_idx;
  logic                  hi_found;
  logic [2:0]            sel_cmd;
  logic                  sel_eop, sel_flag0;
  logic                  wd_hit;
  logic [TimeoutW-1:0]   wd_next;

  logic [NumApps-1:0]    accept;
  logic                  entropy_req, ins_req, res_req, gen_req, upd_req, uni_req;
  logic                  clr_adata, sts_valid, sts_err, sm_err;

  assign eligible = acmd_avail_i & app_en_i;

  // Round robin: the lowest eligible index at or above rr_q wins, otherwise
  // the lowest eligible index overall (wrap-around).
  always_comb begin
    hi_found    = 1'b0;
    hi_idx      = '0;
    lo_idx      = '0;
    pick_onehot = '0;
    for (int i = NumApps - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_idx = IdxW'(i);
        if (IdxW'(i) >= rr_q) begin
          hi_idx   = IdxW'(i);
          hi_found = 1'b1;
        end
      end
    end
    pick_idx = hi_found ? hi_idx : lo_idx;
    for (int i = 0; i < NumApps; i++) begin
      pick_onehot[i] = (IdxW'(i) == pick_idx);
    end
  end

  always_comb begin
    sel_cmd   = '0;
    sel_eop   = 1'b0;
    sel_flag0 = 1'b0;
    for (int i = 0; i < NumApps; i++) begin
      if (IdxW'(i) == grant_q) begin
        sel_cmd   = acmd_i[3*i +: 3];
        sel_eop   = acmd_eop_i[i];
        sel_flag0 = flag0_i[i];
      end
    end
  end

  // A zero limit disables the watchdog and freezes the counter.
  assign wd_hit  = (timeout_limit_i != '0) && (wdog_q == timeout_limit_i - 1'b1);
  assign wd_next = (timeout_limit_i == '0) ? wdog_q : wdog_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    kind_d      = kind_q;
    wdog_d      = '0;
    timeout_set = 1'b0;
    accept      = '0;
    entropy_req = 1'b0;
    ins_req     = 1'b0;
    res_req     = 1'b0;
    gen_req     = 1'b0;
    upd_req     = 1'b0;
    uni_req     = 1'b0;
    clr_adata   = 1'b0;
    sts_valid   = 1'b0;
    sts_err     = 1'b0;
    sm_err      = 1'b0;

    if (state_q == st_error) begin
      sm_err = 1'b1;
    end else if (state_q > st_comp_wait) begin
      sm_err  = 1'b1;
      state_d = st_error;
    end else if (local_escalate_i) begin
      state_d = st_error;
    end else if (!enable_i) begin
      state_d = st_idle;
    end else begin
      case (state_q)
        st_idle: begin
          if (ctr_drbg_cmd_req_rdy_i && (eligible != '0)) begin
            accept  = pick_onehot;
            grant_d = pick_idx;
            rr_d    = (pick_idx == IdxW'(NumApps - 1)) ? '0 : pick_idx + 1'b1;
            state_d = st_parse;
          end
        end
        st_parse: begin
          if (ctr_drbg_cmd_req_rdy_i && sel_eop) begin
            case (sel_cmd)
              cmd_ins, cmd_res, cmd_gen, cmd_upd, cmd_uni: begin
                kind_d  = sel_cmd;
                state_d = st_prep;
              end
              default: begin
                sts_valid = 1'b1;
                sts_err   = 1'b1;
                state_d   = st_idle;
              end
            endcase
          end
        end
        st_prep: begin
          if (((kind_q == cmd_ins) || (kind_q == cmd_res)) && !sel_flag0) begin
            entropy_req = 1'b1;
            if (cmd_entropy_avail_i) begin
              state_d = st_req;
            end else if (wd_hit) begin
              state_d     = st_error;
              timeout_set = 1'b1;
            end else begin
              wdog_d = wd_next;
            end
          end else begin
            state_d = st_req;
          end
        end
        st_req: begin
          ins_req = (kind_q == cmd_ins);
          res_req = (kind_q == cmd_res);
          gen_req = (kind_q == cmd_gen);
          upd_req = (kind_q == cmd_upd);
          uni_req = (kind_q == cmd_uni);
          state_d = st_clr_adata;
        end
        st_clr_adata: begin
          clr_adata = 1'b1;
          state_d   = st_comp_wait;
        end
        st_comp_wait: begin
          if (cmd_complete_i) begin
            sts_valid = 1'b1;
            state_d   = st_idle;
          end else if (wd_hit) begin
            state_d     = st_error;
            timeout_set = 1'b1;
          end else begin
            wdog_d = wd_next;
          end
        end
        default: begin
          sm_err  = 1'b1;
          state_d = st_error;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= st_idle;
      grant_q       <= '0;
      rr_q          <= '0;
      kind_q        <= '0;
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      kind_q  <= kind_d;
      wdog_q  <= wdog_d;
      if (timeout_set) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign acmd_accept_o      = accept;
  assign cmd_entropy_req_o  = entropy_req;
  assign instant_req_o      = ins_req;
  assign reseed_req_o       = res_req;
  assign generate_req_o     = gen_req;
  assign update_req_o       = upd_req;
  assign uninstant_req_o    = uni_req;
  assign clr_adata_packer_o = clr_adata;
  assign grant_idx_o        = grant_q;
  assign cmd_sts_valid_o    = sts_valid;
  assign cmd_sts_err_o      = sts_err;
  assign main_sm_state_o    = state_q;
  assign main_sm_err_o      = sm_err;
  assign timeout_err_o      = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_csrng_cmd_sched.sv
`default_nettype none
// ============================================================================
// tb_csrng_cmd_sched: scoreboard bench for csrng_cmd_sched.
// Revision: 1.0
// ============================================================================
module tb_csrng_cmd_sched;

  localparam int NumApps = 3;

  // tags: 1 accept (one-hot), 2 request pulses {uni,upd,gen,res,ins}, 3 status (err), 4 clr
  typedef struct {
    int tag;
    int data;
    int delta;  // cycles since previous event, 0 = not checked
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable;
  logic [NumApps-1:0]   app_en;
  logic [NumApps-1:0]   acmd_avail;
  logic [NumApps-1:0]   acmd_accept;
  logic [3*NumApps-1:0] acmd;
  logic [NumApps-1:0]   acmd_eop;
  logic [NumApps-1:0]   flag0;
  logic                 rdy;
  logic                 entropy_req;
  logic                 entropy_avail;
  logic                 ins_req, res_req, gen_req, upd_req, uni_req;
  logic                 clr_adata;
  logic                 cmd_complete;
  logic [15:0]          timeout_limit;
  logic                 escalate;
  logic [1:0]           grant_idx;
  logic                 sts_valid, sts_err;
  logic [3:0]           sm_state;
  logic                 sm_err;
  logic                 timeout_err;

  int   fifo_cnt [NumApps];
  int   comp_dly, ent_dly;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc = 0, last_ev = 0, acc_cyc = 0, err_cyc = 0, ent_hi_cnt = 0;
  int   cw_cnt = 0, pr_cnt = 0;
  logic err_seen = 1'b0;
  logic [3:0] prev_state = 4'd0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NumApps; gi++) begin : g_avail
    assign acmd_avail[gi] = (fifo_cnt[gi] != 0);
  end

  csrng_cmd_sched #(.NumApps(NumApps), .TimeoutW(16)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .enable_i               (enable),
    .app_en_i               (app_en),
    .acmd_avail_i           (acmd_avail),
    .acmd_accept_o          (acmd_accept),
    .acmd_i                 (acmd),
    .acmd_eop_i             (acmd_eop),
    .flag0_i                (flag0),
    .ctr_drbg_cmd_req_rdy_i (rdy),
    .cmd_entropy_req_o      (entropy_req),
    .cmd_entropy_avail_i    (entropy_avail),
    .instant_req_o          (ins_req),
    .reseed_req_o           (res_req),
    .generate_req_o         (gen_req),
    .update_req_o           (upd_req),
    .uninstant_req_o        (uni_req),
    .clr_adata_packer_o     (clr_adata),
    .cmd_complete_i         (cmd_complete),
    .timeout_limit_i        (timeout_limit),
    .local_escalate_i       (escalate),
    .grant_idx_o            (grant_idx),
    .cmd_sts_valid_o        (sts_valid),
    .cmd_sts_err_o          (sts_err),
    .main_sm_state_o        (sm_state),
    .main_sm_err_o          (sm_err),
    .timeout_err_o          (timeout_err)
  );

  task automatic push(input int tag, input int data, input int delta);
    exp_t e;
    e.tag = tag; e.data = data; e.delta = delta;
    exp_q.push_back(e);
  endtask

  // accept, request, clr, status for a command completing in its 2nd CompWait cycle
  task automatic push_cmd(input int app, input int reqbits, input int acc_delta, input int req_delta);
    push(1, 1 << app, acc_delta);
    push(2, reqbits, req_delta);
    push(4, 1, 1);
    push(3, 0, 2);
  endtask

  task automatic observe(input int tag, input int data);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: unexpected event tag=%0d data=%0h at cycle %0d, none expected", tag, data, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.tag != tag || e.data != data || (e.delta != 0 && (cyc - last_ev) != e.delta)) begin
        n_fail++;
        $display("FAIL scoreboard: got tag=%0d data=%0h delta=%0d, expected tag=%0d data=%0h delta=%0d (cycle %0d)",
                 tag, data, cyc - last_ev, e.tag, e.data, e.delta, cyc);
      end
    end
    last_ev = cyc;
  endtask

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (entropy_req) ent_hi_cnt++;
      if (sm_state == 4'd6 && !err_seen) begin
        err_seen = 1'b1;
        err_cyc  = cyc;
      end
      if (acmd_accept != '0) begin
        observe(1, int'(acmd_accept));
        acc_cyc = cyc;
      end
      if ({uni_req, upd_req, gen_req, res_req, ins_req} != 5'd0)
        observe(2, int'({uni_req, upd_req, gen_req, res_req, ins_req}));
      if (clr_adata) observe(4, 1);
      if (sts_valid) observe(3, int'(sts_err));
    end
  end

  // CTR_DRBG / entropy responder and app FIFO model
  initial begin
    cmd_complete  = 1'b0;
    entropy_avail = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (sm_state == 4'd5) cw_cnt++; else cw_cnt = 0;
      if (sm_state == 4'd2) pr_cnt++; else pr_cnt = 0;
      cmd_complete  = (comp_dly != 0) && (cw_cnt == comp_dly);
      entropy_avail = (ent_dly != 0) && (pr_cnt == ent_dly);
      if (sm_state == 4'd1 && prev_state != 4'd1 && fifo_cnt[grant_idx] > 0)
        fifo_cnt[grant_idx]--;
      prev_state = sm_state;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic wait_state(input logic [3:0] code, input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      if (sm_state == code) break;
      step();
    end
    if (i == budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: state %0d not reached, got %0d", name, code, sm_state);
    end
  endtask

  task automatic wait_quiet(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      step();
      if (exp_q.size() == 0 && sm_state == 4'd0) break;
    end
    if (i == budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: %0d expected events outstanding, state %0d", name, exp_q.size(), sm_state);
    end
    step(4);
  endtask

  task automatic set_cmd(input int app, input logic [2:0] code);
    acmd[3*app +: 3] = code;
  endtask

  logic [31:0] quiet_outs;
  assign quiet_outs = {acmd_accept, entropy_req, ins_req, res_req, gen_req, upd_req,
                       uni_req, clr_adata, sts_valid, sts_err};

  initial begin
    rst = 1'b1; enable = 1'b1; app_en = 3'b111; acmd = {3{3'd3}}; acmd_eop = 3'b111;
    flag0 = 3'b000; rdy = 1'b1; timeout_limit = 16'd16; escalate = 1'b0;
    comp_dly = 2; ent_dly = 5;
    foreach (fifo_cnt[i]) fifo_cnt[i] = 0;

    step(3);
    check("reset state", sm_state, 0);
    check("reset grant_idx", grant_idx, 0);
    check("reset timeout_err", timeout_err, 0);
    check("reset outputs", {quiet_outs[28:0], sm_err}, 0);
    rst = 1'b0;
    step();
    check("idle after reset", sm_state, 0);

    // round robin, all avail, GEN
    push_cmd(0, 4, 0, 3);
    push_cmd(1, 4, 1, 3);
    push_cmd(2, 4, 1, 3);
    push_cmd(0, 4, 1, 3);
    fifo_cnt[0] = 2; fifo_cnt[1] = 1; fifo_cnt[2] = 1;
    wait_quiet(200, "round robin");

    // app 2 masked off
    app_en = 3'b011;
    push_cmd(0, 4, 0, 3);
    push_cmd(0, 4, 1, 3);
    fifo_cnt[0] = 2; fifo_cnt[2] = 2;
    wait_quiet(200, "app enable mask");
    check("app2 never accepted", fifo_cnt[2], 2);
    fifo_cnt[2] = 0;
    app_en = 3'b111;

    // INS with entropy wait, then with flag0
    set_cmd(1, 3'd1);
    ent_hi_cnt = 0;
    push_cmd(1, 1, 0, 7);
    fifo_cnt[1] = 1;
    wait_quiet(200, "ins entropy");
    check("entropy req cycles", ent_hi_cnt, 5);
    flag0 = 3'b010;
    ent_hi_cnt = 0;
    push_cmd(1, 1, 0, 3);
    fifo_cnt[1] = 1;
    wait_quiet(200, "ins flag0");
    check("no entropy req with flag0", ent_hi_cnt, 0);
    flag0 = 3'b000;

    // UNI, UPD, RES (entropy) in rr order 2,0,1
    set_cmd(2, 3'd5); set_cmd(0, 3'd4); set_cmd(1, 3'd2);
    push_cmd(2, 16, 0, 3);
    push_cmd(0, 8, 1, 3);
    push_cmd(1, 2, 1, 7);
    fifo_cnt[0] = 1; fifo_cnt[1] = 1; fifo_cnt[2] = 1;
    wait_quiet(300, "mixed commands");

    // illegal command code
    acmd = {3{3'd3}};
    set_cmd(0, 3'd7);
    push(1, 1, 0);
    push(3, 1, 1);
    fifo_cnt[0] = 1;
    wait_quiet(100, "illegal command");
    set_cmd(0, 3'd3);

    // completion watchdog
    timeout_limit = 16'd4; comp_dly = 0; err_seen = 1'b0;
    push(1, 2, 0); push(2, 4, 3); push(4, 1, 1);
    fifo_cnt[1] = 1;
    wait_state(4'd6, 50, "timeout error");
    step(2);
    check("timeout error cycle", err_cyc - acc_cyc, 9);
    check("timeout_err set", timeout_err, 1);
    check("main_sm_err in error", sm_err, 1);
    check("outputs quiet in error", quiet_outs, 0);
    rst = 1'b1;
    step();
    check("reset clears error state", sm_state, 0);
    check("reset clears timeout_err", timeout_err, 0);
    rst = 1'b0;
    step();

    // limit 0 waits forever; disable returns to Idle keeping rr
    timeout_limit = 16'd0;
    push(1, 1, 0); push(2, 4, 3); push(4, 1, 1);
    fifo_cnt[0] = 1;
    wait_state(4'd5, 20, "reach comp wait");
    step(40);
    check("limit 0 still waiting", sm_state, 5);
    check("limit 0 no timeout_err", timeout_err, 0);
    enable = 1'b0;
    step();
    check("disable to idle", sm_state, 0);
    comp_dly = 2; timeout_limit = 16'd16;
    push_cmd(1, 4, 0, 3);
    push_cmd(0, 4, 1, 3);
    fifo_cnt[0] = 1; fifo_cnt[1] = 1;
    step();
    enable = 1'b1;
    wait_quiet(200, "rr kept over disable");

    // escalation during Prep is only cleared by reset
    set_cmd(2, 3'd1); ent_dly = 0; timeout_limit = 16'd0;
    push(1, 4, 0);
    fifo_cnt[2] = 1;
    wait_state(4'd2, 20, "reach prep");
    check("entropy req in prep", entropy_req, 1);
    escalate = 1'b1;
    step();
    escalate = 1'b0;
    check("escalate to error", sm_state, 6);
    check("main_sm_err after escalate", sm_err, 1);
    check("escalate no timeout_err", timeout_err, 0);
    check("outputs quiet after escalate", quiet_outs, 0);
    enable = 1'b0;
    step(3);
    enable = 1'b1;
    step(3);
    check("error survives enable toggle", sm_state, 6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("idle after reset from error", sm_state, 0);
    set_cmd(2, 3'd3); ent_dly = 5;
    push_cmd(0, 4, 0, 3);
    fifo_cnt[0] = 1;
    wait_quiet(100, "operation after reset");

    check("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: bench did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire

// File: doc/csrng_cmd_sched.md
# csrng_cmd_sched

Multi-channel command scheduler for the CSRNG core: arbitrates application command requests from `NumApps` interfaces round-robin, sequences the granted command into the CTR_DRBG request pulses, and tracks completion. It generalises the single-stream CSRNG main state machine with per-app enables, fair arbitration, per-command status reporting and a programmable watchdog on entropy and completion waits. It sits between the app command FIFOs and the CTR_DRBG command stage.

## Interface
- `NumApps`, default 3: number of application command interfaces (≥1); `IdxW = max(1, $clog2(NumApps))`.
- `TimeoutW`, default 16: watchdog counter width.

- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `enable_i` in 1: module enable.
- `app_en_i` in NumApps: per-app arbitration enable mask.
- `acmd_avail_i` in NumApps: app has a command header available.
- `acmd_accept_o` out NumApps: one-hot, one-cycle grant/accept pulse.
- `acmd_i` in 3*NumApps: command code per app, slice `[3*i+:3]`.
- `acmd_eop_i` in NumApps: additional data complete, per app.
- `flag0_i` in NumApps: per-app flag0 (skip entropy request).
- `ctr_drbg_cmd_req_rdy_i` in 1: CTR_DRBG ready.
- `cmd_entropy_req_o` out 1: entropy request.
- `cmd_entropy_avail_i` in 1: entropy available.
- `instant_req_o`, `reseed_req_o`, `generate_req_o`, `update_req_o`, `uninstant_req_o` out 1 each: command request pulses.
- `clr_adata_packer_o` out 1: clear additional-data packer.
- `cmd_complete_i` in 1: CTR_DRBG command done.
- `timeout_limit_i` in TimeoutW: watchdog limit in cycles; 0 disables.
- `local_escalate_i` in 1: fatal escalation.
- `grant_idx_o` out IdxW: index of the current or last granted app.
- `cmd_sts_valid_o` out 1: one-cycle command status pulse.
- `cmd_sts_err_o` out 1: status is error (illegal command); valid with `cmd_sts_valid_o`.
- `main_sm_state_o` out 4: state code.
- `main_sm_err_o` out 1: in error state.
- `timeout_err_o` out 1: sticky, watchdog fired.

## Operation
- State codes: Idle=0, Parse=1, Prep=2, Req=3, ClrAData=4, CompWait=5, Error=6. Codes 7–15 are illegal: go to Error with `main_sm_err_o`=1 in that cycle.
- Precedence each cycle, highest first:
  - state Error;
  - `local_escalate_i` → Error;
  - `!enable_i` → Idle. Grant released, watchdog cleared, no status pulse, RR pointer kept.
  - normal FSM.
- Idle:
  - `eligible = acmd_avail_i & app_en_i`.
  - If `ctr_drbg_cmd_req_rdy_i` and eligible≠0: pick the first eligible index at or after `rr_ptr`, wrapping.
  - Pulse `acmd_accept_o[g]`, latch g into `grant_idx_o`, set `rr_ptr = (g+1) mod NumApps`, go to Parse.
- Parse: when `ctr_drbg_cmd_req_rdy_i && acmd_eop_i[g]`, decode `acmd_i[g]` and latch the kind.
  - INS, RES, GEN, UPD, UNI → Prep.
  - Any other code → Idle with `cmd_sts_valid_o`=1 and `cmd_sts_err_o`=1.
- Prep:
  - INS/RES with `flag0_i[g]`=0: hold `cmd_entropy_req_o`=1 until `cmd_entropy_avail_i`, then go to Req. The watchdog runs.
  - Otherwise go to Req next cycle.
- Req: pulse the kind's request output, go to ClrAData.
- ClrAData: pulse `clr_adata_packer_o`, go to CompWait.
- CompWait: on `cmd_complete_i` go to Idle with `cmd_sts_valid_o`=1 and `cmd_sts_err_o`=0.
- While busy, other apps' requests are ignored. Dropping `app_en_i[g]` mid-command does not abort the command.
- Watchdog:
  - Counter is cleared on entry to Prep and to CompWait, and increments each cycle spent waiting.
  - If `timeout_limit_i`=L≠0 and the awaited event (entropy avail or complete) is still low when the counter equals L−1, go to Error and set `timeout_err_o`.
  - L=0 disables the watchdog; the counter holds.
- Error:
  - `main_sm_err_o`=1; all request, accept and status outputs are 0.
  - `enable_i` and `local_escalate_i` are ignored.
  - Exit only by reset.

## Timing
- Reset values:
  - All outputs 0.
  - State Idle (`main_sm_state_o`=0), `rr_ptr`=0, `grant_idx_o`=0, `timeout_err_o`=0.
- `acmd_accept_o` is combinational from Idle state plus inputs, in the same cycle as avail.
- Minimum latency: accept at t, then Parse at t+1 (eop high), Prep at t+2, Req pulse at t+3, ClrAData at t+4, CompWait at t+5.
- Status pulse is in the cycle `cmd_complete_i` is sampled high.
- Entropy wait: if avail is high at cycle k in Prep, Req is at k+1.
- Timeout: after entry to the wait state at t with the event low through t+L−1, the state is Error at t+L. If the event is high at t+L−1, the normal transition wins.
- Escalate and disable both take effect on the next edge.

## Test plan
- NumApps=3, all apps avail continuously, GEN commands, `cmd_complete_i` 2 cycles after ClrAData → grants in order 0,1,2,0; each `generate_req_o` is 3 cycles after its accept.
- Apps 0 and 2 avail, `app_en_i`=3'b011 → only app 0 is ever granted; app 2 is never accepted.
- INS with `flag0_i`=0, entropy avail 5 cycles after Prep entry → `cmd_entropy_req_o` high 5 cycles, `instant_req_o` next cycle; repeat with `flag0_i`=1 → no entropy request.
- `acmd_i`=3'b111 with eop → Idle next cycle, `cmd_sts_valid_o`=1, `cmd_sts_err_o`=1, no request pulse.
- `timeout_limit_i`=4, `cmd_complete_i` never asserted → Error exactly 4 cycles after CompWait entry, `timeout_err_o`=1; limit 0 → waits indefinitely.
- Additional checks:
  - `local_escalate_i` during Prep → Error; then `enable_i` toggles and `rst_i` pulses → stays Error until reset, returns to Idle after.
  - `enable_i` low during CompWait → Idle, `rr_ptr` retained.
